// File: rtl/sipo_frame_receiver.sv
// LSB-first serial-to-parallel frame receiver with a one-word valid/ready holding register.
// Define SIPO_PARITY_CHECK_EN to add a trailing even-parity bit to each frame and drive parity_err.
module sipo_frame_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SIPO_PARITY_CHECK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state;
    logic [CW-1:0]        bit_cnt;
    logic [FRAME_LEN-1:0] shreg;
    logic [FRAME_LEN-1:0] shreg_nxt;
    logic                 last_bit;
    logic                 word_load;

    // After the final shift, data bit 0 lands at the LSB and any parity bit sits above the data.
    assign shreg_nxt = {serial_in, shreg[FRAME_LEN-1:1]};
    assign last_bit  = (state == SHIFT) && bit_valid && !frame_start &&
                       (bit_cnt == CW'(FRAME_LEN - 1));
    assign word_load = last_bit && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bit_valid && frame_start) begin
                        shreg   <= shreg_nxt;
                        bit_cnt <= CW'(1);
                        state   <= SHIFT;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        shreg <= shreg_nxt;
                        if (frame_start) begin
                            // Restart: older partial bits shift out over the new frame.
                            frame_err <= 1'b1;
                            bit_cnt   <= CW'(1);
                        end else if (last_bit) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            busy    <= 1'b0;
                            if (word_load) begin
                                parallel_out <= shreg_nxt[WIDTH-1:0];
                                out_valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            parity_err <= 1'b0;
        else if (word_load)
            parity_err <= ^shreg_nxt;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver (WIDTH=4) with a scoreboard of expected output words.
module tb_sipo_frame_receiver;

`ifdef SIPO_PARITY_CHECK_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       serial_in;
    logic       bit_valid;
    logic       frame_start;
    logic [3:0] parallel_out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    typedef struct packed {
        logic [3:0] data;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    sipo_frame_receiver #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .parallel_out(parallel_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a transfer happens at the next rising edge whenever valid&&ready here.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL sb_unexpected observed=%0h expected=none", parallel_out);
            end else begin
                e = exp_q.pop_front();
                assert ({parallel_out, parity_err} === {e.data, e.perr}) else begin
                    failures++;
                    $error("FAIL sb_word observed=%0h/%0b expected=%0h/%0b",
                           parallel_out, parity_err, e.data, e.perr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        serial_in   = b;
        bit_valid   = 1'b1;
        frame_start = fs;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d, input int gap, input logic exp_ferr,
                              input logic rdy_last, input logic exp_ovr, input logic bad_par);
        logic [4:0] bits;
        bits = {(^d) ^ bad_par, d};
        for (int i = 0; i < FL; i++) begin
            if (i == FL - 1 && rdy_last) out_ready = 1'b1;
            send_bit(bits[i], i == 0);
            if (i == 0) check("frame_err_first", frame_err, exp_ferr);
            else        check("frame_err_mid", frame_err, 0);
            check("busy_bit", busy, i != FL - 1);
            if (i == FL - 1) begin
                check("overrun_last", overrun, exp_ovr);
                check("out_valid_last", out_valid, 1);
            end else begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("busy_gap", busy, 1);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; out_ready = 1'b0;
        serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
        #3;
        check("rst_out", {parallel_out, out_valid, busy, frame_err, overrun, parity_err}, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Basic frame 1011
        out_ready = 1'b1;
        exp_q.push_back('{4'b1011, 1'b0});
        send_frame(4'b1011, 0, 0, 0, 0, 0);
        check("basic_word", parallel_out, 4'b1011);
        tick();
        check("basic_valid_drop", out_valid, 0);
        check("basic_hold", parallel_out, 4'b1011);

        // Non-start bit in IDLE is ignored
        send_bit(1'b1, 1'b0);
        check("idle_ignore", busy, 0);

        // Gapped bits
        exp_q.push_back('{4'b1011, 1'b0});
        send_frame(4'b1011, 2, 0, 0, 0, 0);
        tick();
        check("gap_valid_drop", out_valid, 0);

        // Restart after two bits
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        check("restart_busy", busy, 1);
        exp_q.push_back('{4'b0110, 1'b0});
        send_frame(4'b0110, 0, 1, 0, 0, 0);
        tick();
        check("restart_valid_drop", out_valid, 0);

        // Backpressure and overrun
        out_ready = 1'b0;
        exp_q.push_back('{4'b1011, 1'b0});
        send_frame(4'b1011, 0, 0, 0, 0, 0);
        send_frame(4'b0101, 0, 0, 0, 1, 0);
        check("ovr_word_kept", parallel_out, 4'b1011);
        tick();
        check("ovr_pulse_end", overrun, 0);
        check("ovr_valid_held", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("ovr_valid_drop", out_valid, 0);

        // Completion and transfer at the same edge
        out_ready = 1'b0;
        exp_q.push_back('{4'b1011, 1'b0});
        send_frame(4'b1011, 0, 0, 0, 0, 0);
        tick();
        check("sim_held", out_valid, 1);
        exp_q.push_back('{4'b1100, 1'b0});
        send_frame(4'b1100, 0, 0, 1, 0, 0);
        check("sim_new_word", parallel_out, 4'b1100);
        tick();
        check("sim_valid_drop", out_valid, 0);

        // Reset mid-frame
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_word", parallel_out, 0);
        check("midrst_flags", {out_valid, frame_err, overrun, parity_err}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        exp_q.push_back('{4'b1001, 1'b0});
        send_frame(4'b1001, 0, 0, 0, 0, 0);
        check("midrst_rx", parallel_out, 4'b1001);
        tick();

`ifdef SIPO_PARITY_CHECK_EN
        exp_q.push_back('{4'b1011, 1'b0});
        send_frame(4'b1011, 0, 0, 0, 0, 0);
        check("parity_good", parity_err, 0);
        tick();
        exp_q.push_back('{4'b1011, 1'b1});
        send_frame(4'b1011, 0, 0, 0, 0, 1);
        check("parity_bad", parity_err, 1);
        tick();
`endif

        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_frame_receiver.md
Name: sipo_frame_receiver

Overview:
- Serial-to-parallel receive stage directly downstream of the 4-bit PISO shifter.
- Collects an LSB-first serial bit stream, framed by a start marker, into a WIDTH-bit word.
- Presents each completed word on a valid/ready output with a one-word holding register, so reception of the next frame overlaps the downstream stall.
- Flags framing restarts and output overruns.

Parameters:
- WIDTH, 4, data bits per frame; legal range 2 to 32.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset, asynchronous assert, active-low.
- serial_in  input  1  serial data bit, LSB first; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies serial_in on this clk edge.
- frame_start  input  1  with bit_valid=1, marks the current bit as bit 0 of a new frame.
- parallel_out  output  WIDTH  received word; stable while out_valid=1.
- out_valid  output  1  parallel_out holds an unconsumed word.
- out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready on a clk edge.
- busy  output  1  frame reception in progress (state SHIFT).
- frame_err  output  1  one-cycle pulse: frame_start seen mid-frame.
- overrun  output  1  one-cycle pulse: completed word dropped because the holding register was full.
- parity_err  output  1  parity result for the held word (see Optional Feature).

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE, bit counter 0, shift register 0, parallel_out 0, out_valid 0, busy 0, frame_err 0, overrun 0, parity_err 0. Deassertion is taken synchronously; the first active edge follows it.
- Bit counter is $clog2(WIDTH+2) bits wide and counts bits captured in the current frame.
- Shift register: on each capture, shift right and insert serial_in at the MSB. After the last data bit, bit 0 sits at the LSB.
- IDLE:
  - bit_valid && frame_start: capture bit, count=1, go to SHIFT.
  - bit_valid without frame_start: bit ignored.
- SHIFT:
  - bit_valid && !frame_start: capture bit, count+1.
  - bit_valid && frame_start: frame_err pulses for one cycle; the partial frame is discarded; this bit is captured as bit 0 and count=1.
  - No bit_valid: hold state and count. There is no timeout.
  - Capture of the last frame bit (count reaches frame length): return to IDLE and perform word completion at the same edge.
- Word completion:
  - Holding register empty, or out_valid && out_ready this edge: load parallel_out from the assembled word and set out_valid=1.
  - Holding register full and out_ready=0: keep the old word, drop the new one, pulse overrun for one cycle.
- Latency: last bit sampled at edge N gives out_valid=1 from edge N onward (visible in the cycle after edge N).
- Transfer (out_valid && out_ready) with no completion at the same edge: out_valid=0 next cycle. parallel_out holds its last value.
- Completion and transfer at the same edge: the new word loads and out_valid stays 1; no overrun.
- Back-to-back frames: a frame_start bit in the cycle right after the last bit is accepted, giving zero idle cycles between frames.
- busy=1 exactly while in SHIFT.
- Reset asserted mid-frame or with a word held: everything clears immediately; the held word is lost.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - Frame length is WIDTH+1 bits; the final bit is an even-parity bit.
  - The parity bit is not stored in parallel_out.
  - parity_err loads together with parallel_out: 1 when the XOR of the data bits and the parity bit is 1.
  - Dropped (overrun) words do not update parity_err.
- Not defined:
  - Frame length is WIDTH bits.
  - parity_err is tied to 0.

Test Plan:
- Basic, WIDTH=4: frame_start with bit 1, then bits 1,0,1 on consecutive cycles, out_ready=1 → parallel_out=4'b1011, out_valid high one cycle, busy high 3 cycles.
- Gapped bits: same frame with bit_valid low 2 cycles between each bit → parallel_out=4'b1011, busy held through the gaps.
- Restart: 2 bits of a frame, then frame_start with bits 0,1,1,0 → frame_err pulses once; parallel_out=4'b0110.
- Backpressure/overrun: out_ready=0, frames 4'b1011 then 4'b0101 back-to-back → overrun pulses when the second completes; parallel_out stays 4'b1011; out_ready=1 → out_valid drops the next cycle.
- Simultaneous completion and transfer: word 4'b1011 held, out_ready=1 at the last bit of 4'b1100 → parallel_out=4'b1100, out_valid stays 1, no overrun.
- Reset mid-frame: reset_n low after 2 bits → all outputs 0 immediately; a following full frame 4'b1001 is received correctly.
- With SIPO_PARITY_CHECK_EN: bits 1,1,0,1 plus parity 1 → parity_err=0; with parity 0 → parity_err=1.
